i2c_target: RTL and testbench
=============================

Name: i2c_target

Overview:
- Receive-side counterpart of the team's I2C controller.
- Samples the single-wire serial line (one bit per clk, MSB first) and frames a start, an 8-bit address, data bytes and an ACK slot.
- On an address match it presents each received byte with a one-cycle valid pulse and drives the acknowledge during the ACK slot.
- Sits on the target side of the bus, feeding a register file or FIFO.

Parameters:
- OWN_ADDR, 8'hA9, full 8-bit address (7-bit address plus R/W bit) this target responds to.
- DATA_W, 8, byte width; fixed at 8, present for package consistency.

Ports:
- clk  input  1  system clock; sda sampled on rising edge.
- rst  input  1  reset; one clock; reset is synchronous and active-low.
- sda  input  1  serial line from controller; idle high.
- sda_ack_n  output  1  acknowledge drive, active-low; 0 = target pulls ACK low.
- data_out  output  8  last received byte, MSB first on the wire.
- data_valid  output  1  one-cycle pulse; data_out is new.
- addr_match  output  1  high from address match until frame end.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (rst==0 at posedge): state=IDLE, bit_cnt=0, shift register=0, data_out=0, data_valid=0, addr_match=0, sda_ack_n=1, busy=0. Reset mid-frame aborts the frame; no data_valid and no ACK for the partial byte.
- States: IDLE, ADDRESS, DATA, ACK. bit_cnt is 3 bits, 0..7, and wraps to 0 on leaving ADDRESS or DATA.
- IDLE: sda==0 is the start → ADDRESS, bit_cnt=0. sda==1 stays in IDLE.
- ADDRESS: shift sda in each cycle. At bit_cnt==7 compare {sr[6:0],sda} to OWN_ADDR:
  - match: addr_match<=1.
  - no match: addr_match<=0, but the frame is still tracked so data bits are not taken as a start.
  - Either way → DATA.
- DATA: shift sda in each cycle. At bit_cnt==7 → ACK. On that edge:
  - if addr_match: data_out<={sr[6:0],sda}, data_valid<=1, sda_ack_n<=0.
  - exception: a continuation byte equal to 8'hFF updates nothing (see release rule below).
- ACK (exactly one cycle): data_valid and sda_ack_n return to 0 and 1 on the edge leaving ACK, so each is asserted for exactly the ACK cycle. sda is ignored. → DATA unconditionally (continuation), bit_cnt=0.
- Latency: data_valid rises on the clk edge that samples the byte's LSB, so it is visible one cycle after the LSB is on the wire.
- Release rule: the line returns high when the controller ends a frame, so a continuation byte of all ones (8'hFF) is treated as line release:
  - no data_valid, no ACK, addr_match<=0, → IDLE.
  - Consequence: the controller must never send 8'hFF as a second or later data byte. The first data byte after the address may be 8'hFF.
- Gap rule: after a frame ends (ACK with no further byte), the line must be held high for at least 8 cycles before the next start. The target returns to IDLE after those 8 cycles.
- Simultaneous events: rst has priority over all transitions. sda is only interpreted as a start in IDLE.
- busy = (state != IDLE), registered with state.

Optional Feature:
- Macro I2C_TGT_GENERAL_CALL_EN.
- Defined: address 8'h00 also matches and is handled identically to OWN_ADDR (data received, ACK driven).
- Undefined: only OWN_ADDR matches; 8'h00 is tracked as a non-matching frame.

Decomposition:
- Shared package i2c_pkg holds:
  - the state enum (IDLE, ADDRESS, DATA, ACK), shared with the controller;
  - BYTE_W=8;
  - IDLE_LEVEL=1'b1;
  - GENERAL_CALL_ADDR=8'h00.
- One natural sub-module: i2c_shift_rx (8-bit MSB-first shift register plus 3-bit bit counter with a "last bit" flag).
- The FSM and outputs stay in i2c_target.

Test Plan:
- Reset: hold rst=0 for 3 cycles with sda toggling → all outputs at reset values, busy=0; release and idle 5 cycles → no activity.
- Single byte: start, addr 8'hA9, data 8'h3C, then sda=1 for 9 cycles → one data_valid with data_out=8'h3C, sda_ack_n=0 for that one cycle, then IDLE, busy=0.
- Wrong address: start, 8'h52, data 8'h11 → no data_valid, sda_ack_n stays 1, busy high through the frame, IDLE after the release byte.
- Multi-byte: start, 8'hA9, bytes 8'hFF, 8'h01, 8'h80, then release → three data_valid pulses (FF, 01, 80), three ACKs, then IDLE.
- Reset mid-frame: assert rst after 4 data bits → next edge gives IDLE, no data_valid; a following clean frame (8'hA9, 8'h5A) is received correctly.
- General call: frame to 8'h00 with 8'h77 → with I2C_TGT_GENERAL_CALL_EN defined, data_valid and data_out=8'h77; without it, no data_valid and no ACK.

Source files
------------

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared I2C state encoding and bus constants.
// Used by both the controller and the target side.
package i2c_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDRESS,
    DATA,
    ACK
  } state_t;

  localparam int          BYTE_W            = 8;
  localparam logic        IDLE_LEVEL        = 1'b1;
  localparam logic [7:0]  GENERAL_CALL_ADDR = 8'h00;

endpackage

// File: rtl/i2c_shift_rx.sv
// i2c_shift_rx: MSB-first receive shifter with 3-bit bit counter.
// rx_byte already includes the bit on the wire this cycle.
module i2c_shift_rx
  import i2c_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              sda,
  input  logic              shift_en,
  output logic [BYTE_W-1:0] rx_byte,
  output logic              last
);

  // The oldest bit is never read back, so only seven are stored.
  logic [BYTE_W-2:0] sr;
  logic [2:0]        bit_cnt;

  assign rx_byte = {sr, sda};
  assign last    = (bit_cnt == 3'd7);

  always_ff @(posedge clk) begin
    if (!rst) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else begin
      if (shift_en) sr <= rx_byte[BYTE_W-2:0];
      bit_cnt <= shift_en ? bit_cnt + 3'd1 : 3'd0;
    end
  end

endmodule

// File: rtl/i2c_target.sv
// i2c_target: receive-side I2C framer with address match and ACK.
// Define I2C_TGT_GENERAL_CALL_EN to also accept address 8'h00.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [7:0] OWN_ADDR = 8'hA9,
  parameter int         DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sda,
  output logic              sda_ack_n,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              addr_match,
  output logic              busy
);

  state_t            state, state_n;
  logic              first, first_n;
  logic [DATA_W-1:0] data_n;
  logic              valid_n, ack_n_n, match_n, hit;
  logic [BYTE_W-1:0] rx_byte;
  logic              last;

  i2c_shift_rx u_rx (
    .clk      (clk),
    .rst      (rst),
    .sda      (sda),
    .shift_en (state == ADDRESS || state == DATA),
    .rx_byte  (rx_byte),
    .last     (last)
  );

`ifdef I2C_TGT_GENERAL_CALL_EN
  assign hit = (rx_byte == OWN_ADDR) ||
               (rx_byte == GENERAL_CALL_ADDR);
`else
  assign hit = (rx_byte == OWN_ADDR);
`endif

  always_comb begin
    state_n = state;
    first_n = first;
    data_n  = data_out;
    match_n = addr_match;
    valid_n = 1'b0;
    ack_n_n = 1'b1;
    unique case (state)
      IDLE: begin
        if (sda != IDLE_LEVEL) state_n = ADDRESS;
      end
      ADDRESS: begin
        if (last) begin
          state_n = DATA;
          first_n = 1'b1;
          match_n = hit;
        end
      end
      DATA: begin
        // An all-ones continuation byte is the line released.
        if (last) begin
          if (!first && rx_byte == {BYTE_W{IDLE_LEVEL}}) begin
            state_n = IDLE;
            match_n = 1'b0;
          end else begin
            state_n = ACK;
            first_n = 1'b0;
            if (addr_match) begin
              data_n  = rx_byte;
              valid_n = 1'b1;
              ack_n_n = 1'b0;
            end
          end
        end
      end
      ACK: begin
        state_n = DATA;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      first      <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      sda_ack_n  <= 1'b1;
      addr_match <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      first      <= first_n;
      data_out   <= data_n;
      data_valid <= valid_n;
      sda_ack_n  <= ack_n_n;
      addr_match <= match_n;
      busy       <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: frame-level timeline model of i2c_target.
// Honours I2C_TGT_GENERAL_CALL_EN the same way as the design.
module tb_i2c_target;

  localparam logic [7:0] OWN = 8'hA9;

  typedef struct packed {
    logic       busy;
    logic       match;
    logic       valid;
    logic       ack_n;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       sda;
  logic       sda_ack_n;
  logic [7:0] data_out;
  logic       data_valid;
  logic       addr_match;
  logic       busy;

  logic       sda_q [$];
  logic       rst_q [$];
  exp_t       exp_q [$];
  logic [7:0] got_q [$];
  logic [7:0] cur_data = 8'h00;
  logic [7:0] lit [6];
  exp_t       ce;
  int         idx = 0;
  bit         chk = 1'b0;
  int         checks = 0;
  int         fails = 0;
  int         acks = 0;
  int         nv;

  i2c_target #(.OWN_ADDR(OWN), .DATA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .sda        (sda),
    .sda_ack_n  (sda_ack_n),
    .data_out   (data_out),
    .data_valid (data_valid),
    .addr_match (addr_match),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Queue one cycle: inputs for the edge and outputs seen after it.
  task automatic push(input logic s, input logic r,
                      input logic b, input logic m, input logic v);
    exp_t e;
    sda_q.push_back(s);
    rst_q.push_back(r);
    e.busy  = b;
    e.match = m;
    e.valid = v;
    e.ack_n = ~v;
    e.data  = cur_data;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) push(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    cur_data = 8'h00;
    for (int i = 0; i < n; i++)
      push(i[0], 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // cut >= 0 stops after that many bits of the first data byte.
  task automatic frame(input logic [7:0] addr, input int n,
                       input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input int cut);
    logic [7:0] d [3];
    logic       m;
    d[0] = b0;
    d[1] = b1;
    d[2] = b2;
    m = (addr == OWN);
`ifdef I2C_TGT_GENERAL_CALL_EN
    if (addr == 8'h00) m = 1'b1;
`endif
    push(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int b = 7; b >= 0; b--)
      push(addr[b], 1'b1, 1'b1, (b == 0) ? m : 1'b0, 1'b0);
    for (int k = 0; k < n; k++) begin
      for (int b = 7; b >= 0; b--) begin
        if (cut >= 0 && k == 0 && (7 - b) == cut) return;
        if (b == 0 && m) cur_data = d[k];
        push(d[k][b], 1'b1, 1'b1, m, (b == 0) && m);
      end
      push(1'b0, 1'b1, 1'b1, m, 1'b0);
    end
    for (int b = 7; b >= 0; b--)
      push(1'b1, 1'b1, b != 0, (b != 0) && m, 1'b0);
  endtask

  always @(negedge clk) begin
    if (chk) begin
      ce = exp_q[idx];
      checks++;
      if ({busy, addr_match, data_valid, sda_ack_n, data_out} !== ce) begin
        fails++;
        $display("FAIL cycle %0d: got busy=%b match=%b valid=%b ack_n=%b data=%h, want busy=%b match=%b valid=%b ack_n=%b data=%h",
                 idx, busy, addr_match, data_valid, sda_ack_n, data_out,
                 ce.busy, ce.match, ce.valid, ce.ack_n, ce.data);
      end
      if (data_valid === 1'b1) got_q.push_back(data_out);
      if (sda_ack_n === 1'b0) acks++;
    end
  end

  initial begin
    rst = 1'b0;
    sda = 1'b1;
    lit[0] = 8'h3C;
    lit[1] = 8'hFF;
    lit[2] = 8'h01;
    lit[3] = 8'h80;
    lit[4] = 8'h5A;
    lit[5] = 8'h77;
`ifdef I2C_TGT_GENERAL_CALL_EN
    nv = 6;
`else
    nv = 5;
`endif

    do_reset(3);
    idle(5);
    frame(8'hA9, 1, 8'h3C, 8'h00, 8'h00, -1);
    idle(2);
    frame(8'h52, 1, 8'h11, 8'h00, 8'h00, -1);
    idle(2);
    frame(8'hA9, 3, 8'hFF, 8'h01, 8'h80, -1);
    idle(2);
    frame(8'hA9, 1, 8'hC3, 8'h00, 8'h00, 4);
    do_reset(1);
    idle(2);
    frame(8'hA9, 1, 8'h5A, 8'h00, 8'h00, -1);
    idle(2);
    frame(8'h00, 1, 8'h77, 8'h00, 8'h00, -1);
    idle(3);

    for (int i = 0; i < sda_q.size(); i++) begin
      sda = sda_q[i];
      rst = rst_q[i];
      @(posedge clk);
      #1;
      idx = i;
      chk = 1'b1;
    end
    @(negedge clk);
    #1;
    chk = 1'b0;

    checks++;
    if (got_q.size() != nv) begin
      fails++;
      $display("FAIL pulse_count: got %0d want %0d", got_q.size(), nv);
    end
    for (int i = 0; i < nv && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== lit[i]) begin
        fails++;
        $display("FAIL byte_%0d: got %h want %h", i, got_q[i], lit[i]);
      end
    end
    checks++;
    if (acks != nv) begin
      fails++;
      $display("FAIL ack_count: got %0d want %0d", acks, nv);
    end
    checks++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL final_busy: got %b want 0", busy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
